// File: rtl/hazard_stall_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_unit_if
//  Description : Bundle between the ID-stage pipeline control and the hazard
//                stall unit. The pipeline side (master) drives the ID/EX/MEM
//                register fields. The unit (slave) returns the write enables,
//                the bubble and flush controls, and the performance and error
//                status.
//  Signals     : IFID_opcode/Rs/Rt       - instruction currently in ID
//                IDEX_MemRead/RegWrite/WriteReg - instruction in EX
//                EXMEM_MemRead/WriteReg  - instruction in MEM
//                branch_taken            - ID comparator result
//                PCWrite, IFIDWrite, IDEX_bubble, IFID_flush - pipeline controls
//                stall_cnt, flush_cnt    - saturating event counters
//                stall_err               - sticky runaway-stall flag
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_stall_unit_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       IFID_opcode;
    logic [4:0]       IFID_RegisterRs;
    logic [4:0]       IFID_RegisterRt;
    logic             IDEX_MemRead;
    logic             IDEX_RegWrite;
    logic [4:0]       IDEX_WriteReg;
    logic             EXMEM_MemRead;
    logic [4:0]       EXMEM_WriteReg;
    logic             branch_taken;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IDEX_bubble;
    logic             IFID_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             stall_err;

    modport master (
        output IFID_opcode, IFID_RegisterRs, IFID_RegisterRt,
               IDEX_MemRead, IDEX_RegWrite, IDEX_WriteReg,
               EXMEM_MemRead, EXMEM_WriteReg, branch_taken,
        input  PCWrite, IFIDWrite, IDEX_bubble, IFID_flush,
               stall_cnt, flush_cnt, stall_err
    );

    modport slave (
        input  IFID_opcode, IFID_RegisterRs, IFID_RegisterRt,
               IDEX_MemRead, IDEX_RegWrite, IDEX_WriteReg,
               EXMEM_MemRead, EXMEM_WriteReg, branch_taken,
        output PCWrite, IFIDWrite, IDEX_bubble, IFID_flush,
               stall_cnt, flush_cnt, stall_err
    );
endinterface
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_unit
//  Description : ID-stage stall/flush generator. Detects load-use hazards and
//                branch-operand hazards that forwarding cannot resolve, and
//                drives PC/IF-ID write enables, the ID/EX bubble and the IF/ID
//                flush in the same cycle (Mealy). Tracks stall runs with a
//                RUN/STALL FSM, counts stalls and flushes (saturating), and
//                raises a sticky error when a run exceeds MAX_STALL cycles.
//  Ports       : clock - rising-edge clock
//                reset - asynchronous active-low reset
//                hz    - hazard_stall_unit_if slave modport (see interface)
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_unit #(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 2
) (
    input  wire logic         clock,
    input  wire logic         reset,
    hazard_stall_unit_if.slave hz
);

    localparam logic [5:0] OP_R_FORMAT = 6'd0;
    localparam logic [5:0] OP_BEQ      = 6'd4;
    localparam logic [5:0] OP_BNE      = 6'd5;
    localparam logic [5:0] OP_ADDI     = 6'd8;
    localparam logic [5:0] OP_LW       = 6'd35;
    localparam logic [5:0] OP_SW       = 6'd43;

    localparam logic [2:0] RUN_MAX   = 3'd7;
    localparam logic [2:0] STALL_LIM = 3'(MAX_STALL);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [2:0]       run_cnt, run_next;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             stall_err_q;

    logic             uses_rs, uses_rt, is_br;
    logic             lu, bex, bmem, stall, flush;

    // Operand usage by opcode; unknown opcodes read nothing and never stall.
    always_comb begin
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        is_br   = 1'b0;
        unique case (hz.IFID_opcode)
            OP_R_FORMAT, OP_SW: begin uses_rs = 1'b1; uses_rt = 1'b1; end
            OP_BEQ, OP_BNE: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
                is_br   = 1'b1;
            end
            OP_ADDI, OP_LW: uses_rs = 1'b1;
            default: ;
        endcase
    end

    function automatic logic reg_match(input logic [4:0] r, input logic urs,
                                       input logic urt, input logic [4:0] rs,
                                       input logic [4:0] rt);
        return (r != 5'd0) && ((urs && (r == rs)) || (urt && (r == rt)));
    endfunction

    always_comb begin
        lu    = hz.IDEX_MemRead &&
                reg_match(hz.IDEX_WriteReg, uses_rs, uses_rt,
                          hz.IFID_RegisterRs, hz.IFID_RegisterRt);
        // A branch resolved in ID also needs an ALU result still in EX.
        bex   = is_br && hz.IDEX_RegWrite &&
                reg_match(hz.IDEX_WriteReg, uses_rs, uses_rt,
                          hz.IFID_RegisterRs, hz.IFID_RegisterRt);
        // A load in MEM has no data yet for a branch comparing in ID.
        bmem  = is_br && hz.EXMEM_MemRead &&
                reg_match(hz.EXMEM_WriteReg, uses_rs, uses_rt,
                          hz.IFID_RegisterRs, hz.IFID_RegisterRt);
        stall = lu | bex | bmem;
        // A stalling branch holds its flush until the stall clears.
        flush = hz.branch_taken && !stall;
    end

    // Pipeline controls; reset forces a frozen front end with a bubble.
    always_comb begin
        hz.PCWrite     = 1'b0;
        hz.IFIDWrite   = 1'b0;
        hz.IDEX_bubble = 1'b1;
        hz.IFID_flush  = 1'b0;
        if (reset) begin
            hz.PCWrite     = !stall;
            hz.IFIDWrite   = !stall;
            hz.IDEX_bubble = stall;
            hz.IFID_flush  = flush;
        end
    end

    // Next-state and run-length logic.
    always_comb begin
        state_next = state;
        run_next   = 3'd0;
        unique case (state)
            RUN:     state_next = stall ? STALL : RUN;
            STALL:   state_next = stall ? STALL : RUN;
            default: state_next = RUN;
        endcase
        if (stall) begin
            run_next = (run_cnt == RUN_MAX) ? RUN_MAX : run_cnt + 3'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            run_cnt <= 3'd0;
        end else begin
            state   <= state_next;
            run_cnt <= run_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
            // run_cnt already counts MAX_STALL stalled edges; one more is too long.
            if (stall && (run_cnt == STALL_LIM)) begin
                stall_err_q <= 1'b1;
            end
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
    assign hz.stall_err = stall_err_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_stall_unit
//  Description : Directed-vector bench for hazard_stall_unit. Each vector's
//                hand-computed response is queued when driven; a monitor on
//                the falling edge pops and compares. A second instance with
//                4-bit counters shares the same inputs to show saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_unit;

    localparam logic [5:0] R  = 6'd0;
    localparam logic [5:0] LW = 6'd35;
    localparam logic [5:0] SW = 6'd43;
    localparam logic [5:0] BQ = 6'd4;
    localparam logic [5:0] BN = 6'd5;
    localparam logic [5:0] AI = 6'd8;
    localparam logic [5:0] JX = 6'd2;

    logic clock;
    logic reset;

    hazard_stall_unit_if #(.CNT_W(16)) hz  ();
    hazard_stall_unit_if #(.CNT_W(4))  hz4 ();

    hazard_stall_unit #(.CNT_W(16), .MAX_STALL(2)) dut (
        .clock (clock),
        .reset (reset),
        .hz    (hz.slave)
    );

    hazard_stall_unit #(.CNT_W(4), .MAX_STALL(2)) dut4 (
        .clock (clock),
        .reset (reset),
        .hz    (hz4.slave)
    );

    assign hz4.IFID_opcode     = hz.IFID_opcode;
    assign hz4.IFID_RegisterRs = hz.IFID_RegisterRs;
    assign hz4.IFID_RegisterRt = hz.IFID_RegisterRt;
    assign hz4.IDEX_MemRead    = hz.IDEX_MemRead;
    assign hz4.IDEX_RegWrite   = hz.IDEX_RegWrite;
    assign hz4.IDEX_WriteReg   = hz.IDEX_WriteReg;
    assign hz4.EXMEM_MemRead   = hz.EXMEM_MemRead;
    assign hz4.EXMEM_WriteReg  = hz.EXMEM_WriteReg;
    assign hz4.branch_taken    = hz.branch_taken;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int   tag;
        logic stl;
        logic fl;
        logic err;
        int   scnt;
        int   fcnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   tag    = 0;

    // Drive one cycle of inputs and queue what the DUT must show this cycle.
    task automatic vec(input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic idex_mr,
                       input logic idex_rw, input logic [4:0] idex_wr,
                       input logic exm_mr, input logic [4:0] exm_wr,
                       input logic bt, input logic rstn,
                       input logic e_stl, input logic e_fl,
                       input int e_scnt, input int e_fcnt, input logic e_err);
        exp_t e;
        reset              = rstn;
        hz.IFID_opcode     = op;
        hz.IFID_RegisterRs = rs;
        hz.IFID_RegisterRt = rt;
        hz.IDEX_MemRead    = idex_mr;
        hz.IDEX_RegWrite   = idex_rw;
        hz.IDEX_WriteReg   = idex_wr;
        hz.EXMEM_MemRead   = exm_mr;
        hz.EXMEM_WriteReg  = exm_wr;
        hz.branch_taken    = bt;
        e.tag  = tag;
        e.stl  = e_stl;
        e.fl   = e_fl;
        e.err  = e_err;
        e.scnt = e_scnt;
        e.fcnt = e_fcnt;
        q.push_back(e);
        tag++;
        @(posedge clock);
        #1;
    endtask

    // Monitor: the controls are valid every cycle, so compare mid-cycle.
    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            int   s4;
            logic [4:0] act, req;
            e   = q.pop_front();
            s4  = (e.scnt > 15) ? 15 : e.scnt;
            act = {hz.PCWrite, hz.IFIDWrite, hz.IDEX_bubble, hz.IFID_flush,
                   hz.stall_err};
            req = {!e.stl, !e.stl, e.stl, e.fl, e.err};
            n_cmp++;
            if (act !== req || int'(hz.stall_cnt) != e.scnt ||
                int'(hz.flush_cnt) != e.fcnt || int'(hz4.stall_cnt) != s4) begin
                n_fail++;
                $display("FAIL v%0d pc/ifid/bub/flush/err got %b want %b stall_cnt got %0d want %0d flush_cnt got %0d want %0d stall_cnt4 got %0d want %0d",
                         e.tag, act, req, hz.stall_cnt, e.scnt, hz.flush_cnt,
                         e.fcnt, hz4.stall_cnt, s4);
            end
        end
    end

    initial begin
        reset = 1'b0;
        hz.IFID_opcode = R; hz.IFID_RegisterRs = 0; hz.IFID_RegisterRt = 0;
        hz.IDEX_MemRead = 0; hz.IDEX_RegWrite = 0; hz.IDEX_WriteReg = 0;
        hz.EXMEM_MemRead = 0; hz.EXMEM_WriteReg = 0; hz.branch_taken = 0;
        @(posedge clock);
        #1;
        //   op  rs rt  imr irw iwr emr ewr bt rstn  stl fl scnt fcnt err
        // reset state
        vec(R,  0, 0,  0, 0, 0,  0, 0,  0, 0,   1, 0, 0, 0, 0);
        // load-use: LW $2 in EX, ADD $3,$2,$4 in ID
        vec(R,  2, 4,  1, 1, 2,  0, 0,  0, 1,   1, 0, 0, 0, 0);
        vec(R,  2, 4,  0, 0, 0,  1, 2,  0, 1,   0, 0, 1, 0, 0);
        // ADDI $5 in EX, BEQ $5,$0 in ID: one stall, then flush
        vec(BQ, 5, 0,  0, 1, 5,  0, 0,  1, 1,   1, 0, 1, 0, 0);
        vec(BQ, 5, 0,  0, 0, 0,  0, 5,  1, 1,   0, 1, 2, 0, 0);
        vec(R,  0, 0,  0, 0, 0,  0, 0,  0, 1,   0, 0, 2, 1, 0);
        // LW $7 then BNE $7,$8: BEX then BMEM, no error at two
        vec(BN, 7, 8,  1, 1, 7,  0, 0,  0, 1,   1, 0, 2, 1, 0);
        vec(BN, 7, 8,  0, 0, 0,  1, 7,  0, 1,   1, 0, 3, 1, 0);
        vec(BN, 7, 8,  0, 0, 0,  0, 0,  1, 1,   0, 1, 4, 1, 0);
        // same again but held a third cycle: error becomes sticky
        vec(BN, 7, 8,  1, 1, 7,  0, 0,  0, 1,   1, 0, 4, 2, 0);
        vec(BN, 7, 8,  0, 0, 0,  1, 7,  0, 1,   1, 0, 5, 2, 0);
        vec(BN, 7, 8,  0, 0, 0,  1, 7,  0, 1,   1, 0, 6, 2, 0);
        vec(R,  0, 0,  0, 0, 0,  0, 0,  0, 1,   0, 0, 7, 2, 1);
        vec(R,  0, 0,  0, 0, 0,  0, 0,  0, 1,   0, 0, 7, 2, 1);
        // $0 never stalls; SW rt matches; ADDI rt and unknown opcode do not
        vec(R,  0, 0,  1, 1, 0,  0, 0,  0, 1,   0, 0, 7, 2, 1);
        vec(SW, 1, 9,  1, 1, 9,  0, 0,  0, 1,   1, 0, 7, 2, 1);
        vec(AI, 1, 9,  1, 1, 9,  0, 0,  0, 1,   0, 0, 8, 2, 1);
        vec(JX, 9, 9,  1, 1, 9,  1, 9,  0, 1,   0, 0, 8, 2, 1);
        // LU and BMEM together count once
        vec(BQ, 3, 4,  1, 1, 3,  1, 4,  0, 1,   1, 0, 8, 2, 1);
        vec(R,  0, 0,  0, 0, 0,  0, 0,  0, 1,   0, 0, 9, 2, 1);
        // reset mid-stall, then release with no hazard
        vec(R,  2, 4,  1, 1, 2,  0, 0,  0, 1,   1, 0, 9, 2, 1);
        vec(R,  0, 0,  0, 0, 0,  0, 0,  1, 0,   1, 0, 0, 0, 0);
        vec(R,  0, 0,  0, 0, 0,  0, 0,  0, 1,   0, 0, 0, 0, 0);
        vec(R,  0, 0,  0, 0, 0,  0, 0,  1, 1,   0, 1, 0, 0, 0);
        // 20 stall cycles: 4-bit counter holds at 15
        for (int i = 0; i < 20; i++) begin
            vec(R, 2, 4, 1, 1, 2, 0, 0, 0, 1, 1, 0, i, 1, (i >= 3));
        end
        vec(R,  0, 0,  0, 0, 0,  0, 0,  0, 1,   0, 0, 20, 1, 1);
        @(negedge clock);
        #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- ID-stage stall and flush generator; the producer-side partner of the EX-stage forwarding unit.
- Detects hazards that bypassing cannot cover:
  - load-use;
  - a branch compared in ID whose operand is still in flight.
- Drives PC/IF-ID write enables, the ID/EX bubble and the IF/ID flush.
- Tracks stall episodes with a small FSM, saturating performance counters and a sticky runaway-stall error.

Parameters:
- CNT_W, 16, width of performance counters
- MAX_STALL, 2, longest legal consecutive stall run in cycles; a longer run sets stall_err

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous active-low reset
- IFID_opcode  in  6  opcode of instruction in ID
- IFID_RegisterRs  in  5  rs of ID instruction
- IFID_RegisterRt  in  5  rt of ID instruction
- IDEX_MemRead  in  1  EX instruction is a load
- IDEX_RegWrite  in  1  EX instruction writes a register
- IDEX_WriteReg  in  5  EX destination after RegDst mux
- EXMEM_MemRead  in  1  MEM instruction is a load
- EXMEM_WriteReg  in  5  MEM destination
- branch_taken  in  1  ID comparator result, BEQ/BNE with BneEn already applied
- PCWrite  out  1  PC update enable
- IFIDWrite  out  1  IF/ID register enable
- IDEX_bubble  out  1  zero ID/EX control fields this edge
- IFID_flush  out  1  zero IF/ID instruction this edge
- stall_cnt  out  CNT_W  total stall cycles, saturating
- flush_cnt  out  CNT_W  total flushes, saturating
- stall_err  out  1  sticky: stall run exceeded MAX_STALL

Behaviour:
- Opcode classes (constants.h):
  - R_FORMAT=0, LW=35, SW=43, BEQ=4, BNE=5, ADDI=8.
  - uses_rs: all six.
  - uses_rt: R_FORMAT, SW, BEQ, BNE.
  - is_br: BEQ, BNE.
  - Unknown opcode: uses neither rs nor rt, so it never stalls.
- Register match rule:
  - match(X) = X!=0 && ((uses_rs && X==IFID_RegisterRs) || (uses_rt && X==IFID_RegisterRt)).
  - Register 0 never causes a stall.
- Hazard terms, combinational:
  - LU = IDEX_MemRead && match(IDEX_WriteReg).
  - BEX = is_br && IDEX_RegWrite && match(IDEX_WriteReg).
  - BMEM = is_br && EXMEM_MemRead && match(EXMEM_WriteReg).
  - stall = LU | BEX | BMEM.
- Outputs, Mealy, same cycle as detection, zero added latency:
  - PCWrite = IFIDWrite = !stall.
  - IDEX_bubble = stall.
  - IFID_flush = branch_taken && !stall.
  - A branch that is stalling never flushes; its flush happens in the cycle its stall clears.
- Resulting stall lengths:
  - ALU producer → branch: 1 stall cycle.
  - Load → branch: 2 (BEX, then BMEM).
  - Load → non-branch: 1.
  - Hazard and flush terms are re-evaluated every cycle; no stall length is pre-counted.
- While reset is low, outputs override to PCWrite=0, IFIDWrite=0, IDEX_bubble=1, IFID_flush=0.
- FSM states: RUN, STALL.
  - RUN → STALL on stall.
  - STALL → STALL while stall.
  - STALL → RUN when !stall.
- run counter:
  - 3-bit, cleared in RUN, incremented each STALL cycle, saturates at 7.
  - On entering STALL, the run count is 1.
  - If run count == MAX_STALL and stall is still high, stall_err is set on that edge.
  - stall_err is sticky until reset.
- Performance counters:
  - stall_cnt increments on each rising edge where stall=1.
  - flush_cnt increments on each edge where IFID_flush=1.
  - Both saturate at all-ones and never wrap.
- Reset (async, reset low):
  - state=RUN, run count=0, stall_cnt=0, flush_cnt=0, stall_err=0.
  - Asserting reset mid-stall aborts the run immediately.
  - On release, the first edge evaluates the hazard terms afresh.
- Simultaneous events: LU and BMEM may both hold; stall counts once per cycle.

Test Plan:
- LW $2,0($1) in EX, ADD $3,$2,$4 in ID:
  - one cycle PCWrite=0, IFIDWrite=0, IDEX_bubble=1;
  - next cycle all clear;
  - stall_cnt=1.
- ADDI $5 in EX (IDEX_RegWrite=1, WriteReg=5), BEQ $5,$0 in ID:
  - 1 stall cycle;
  - after stall, branch_taken=1 gives IFID_flush=1 for one cycle;
  - flush_cnt=1.
- LW $7 then BNE $7,$8:
  - two consecutive stall cycles (BEX, then BMEM);
  - stall_err stays 0 with MAX_STALL=2;
  - force a third stall cycle and stall_err=1, sticky.
- LW writing $0, dependent R-type reading $0:
  - no stall;
  - SW with rt match on a load in EX does stall;
  - ADDI whose rt field matches does not stall.
- Reset asserted mid-stall:
  - counters 0, stall_err 0, outputs at reset values;
  - release with no hazard gives PCWrite=1 on the first cycle.
- CNT_W=4 with 20 stall cycles → stall_cnt holds at 15.
